// File: rtl/count_uptimer.sv
// Up-counting timer: latches a terminal value, counts up by prescaled ticks, inc pulses or doubling.
// Optional build macro UPTIMER_IRQ_EN adds a one-cycle done_pulse output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for a latch
// S_ARMED | terminal loaded, manual inc/mul2 only
// S_RUN   | manual ops plus prescaled auto ticks
// S_DONE  | value frozen at terminal, full=1; left only by latch or rst
module count_uptimer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             start,
    input  logic             inc,
    input  logic             mul2,
    output logic [WIDTH-1:0] value,
    output logic             full,
    output logic             busy,
`ifdef UPTIMER_IRQ_EN
    output logic             done_pulse,
`endif
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       presc;
    logic [7:0]       presc_nxt;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] term_nxt;
    logic [WIDTH-1:0] value_nxt;
    logic             ovf_nxt;
    logic [WIDTH:0]   next_calc;
    logic             active;
    logic             tick;
    logic             hit;

    assign active = (state == S_ARMED) || (state == S_RUN);
    assign tick   = (state == S_RUN) && (presc == PRESC_LAST);

    // One extra bit so a doubling that shifts out a 1 is both seen and saturates.
    always_comb begin
        next_calc = '0;
        if (mul2)
            next_calc = {value, 1'b0};
        else
            next_calc = {1'b0, value} + {{WIDTH{1'b0}}, inc} + {{WIDTH{1'b0}}, tick};
        hit = active && (next_calc >= {1'b0, terminal});
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (latch) begin
            state_nxt = (in == '0) ? S_DONE : S_ARMED;
        end else begin
            case (state)
                S_ARMED: begin
                    if (hit)
                        state_nxt = S_DONE;
                    else if (start)
                        state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (hit)
                        state_nxt = S_DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        value_nxt = value;
        ovf_nxt   = overflow;
        presc_nxt = presc;
        term_nxt  = terminal;
        if (latch) begin
            term_nxt  = in;
            value_nxt = '0;
            ovf_nxt   = 1'b0;
            presc_nxt = '0;
        end else if (active) begin
            if (mul2 && next_calc[WIDTH])
                ovf_nxt = 1'b1;
            value_nxt = hit ? terminal : next_calc[WIDTH-1:0];
            // The prescaler keeps wrapping even when a coincident mul2 swallows the tick.
            if (state == S_RUN)
                presc_nxt = tick ? 8'd0 : presc + 8'd1;
            else if (start)
                presc_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value    <= '0;
            terminal <= '0;
            presc    <= '0;
            overflow <= 1'b0;
            full     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            value    <= value_nxt;
            terminal <= term_nxt;
            presc    <= presc_nxt;
            overflow <= ovf_nxt;
            full     <= (state_nxt == S_DONE);
            busy     <= (state_nxt == S_RUN);
        end
    end

`ifdef UPTIMER_IRQ_EN
    // A fresh latch into DONE counts as a new entry; idling in DONE does not.
    always_ff @(posedge clk) begin
        if (rst)
            done_pulse <= 1'b0;
        else
            done_pulse <= (state_nxt == S_DONE) && ((state != S_DONE) || latch);
    end
`endif

endmodule

// File: tb/tb_count_uptimer.sv
// Bench for count_uptimer: directed scenarios with literal expectations plus
// a randomized run, all compared every cycle against a behavioural model.
module tb_count_uptimer;
    localparam int W = 8;
    localparam int P = 4;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         latch = 1'b0, start = 1'b0, inc = 1'b0, mul2 = 1'b0;
    logic [W-1:0] value;
    logic         full, busy, overflow;
`ifdef UPTIMER_IRQ_EN
    logic         done_pulse;
`endif

    count_uptimer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk),
        .rst(rst),
        .in(din),
        .latch(latch),
        .start(start),
        .inc(inc),
        .mul2(mul2),
        .value(value),
        .full(full),
        .busy(busy),
`ifdef UPTIMER_IRQ_EN
        .done_pulse(done_pulse),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, ticks derived from cycles elapsed since start.
    int m_state = M_IDLE;
    int m_val   = 0;
    int m_term  = 0;
    int m_ovf   = 0;
    int m_since = 0;
    int m_dp    = 0;

    always @(posedge clk) begin
        int prev;
        int nxt;
        int tk;
        prev = m_state;
        m_dp = 0;
        if (rst) begin
            m_state = M_IDLE; m_val = 0; m_term = 0; m_ovf = 0; m_since = 0;
        end else if (latch) begin
            m_term  = int'(din);
            m_val   = 0;
            m_ovf   = 0;
            m_since = 0;
            m_state = (din == 0) ? M_DONE : M_ARMED;
            m_dp    = (m_state == M_DONE) ? 1 : 0;
        end else if (m_state == M_ARMED || m_state == M_RUN) begin
            tk = 0;
            if (m_state == M_RUN) begin
                m_since++;
                tk = (m_since % P == 0) ? 1 : 0;
            end
            nxt = mul2 ? m_val * 2 : m_val + int'(inc) + tk;
            if (mul2 && nxt >= (1 << W))
                m_ovf = 1;
            if (nxt >= m_term) begin
                m_val   = m_term;
                m_state = M_DONE;
            end else begin
                m_val = nxt;
                if (m_state == M_ARMED && start) begin
                    m_state = M_RUN;
                    m_since = 0;
                end
            end
            m_dp = (prev != M_DONE && m_state == M_DONE) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("value", int'(value), m_val);
            check("full", int'(full), (m_state == M_DONE) ? 1 : 0);
            check("busy", int'(busy), (m_state == M_RUN) ? 1 : 0);
            check("overflow", int'(overflow), m_ovf);
`ifdef UPTIMER_IRQ_EN
            check("done_pulse", int'(done_pulse), m_dp);
`endif
        end
    end

    task automatic step(input bit l, input bit s, input bit i, input bit m, input int d);
        latch = l; start = s; inc = i; mul2 = m; din = W'(d);
        @(posedge clk);
        #1;
        latch = 1'b0; start = 1'b0; inc = 1'b0; mul2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("rst_value", int'(value), 0);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(overflow), 0);

        // Auto ticks only: 17 ticks of 4 cycles each.
        step(1, 0, 0, 0, 17);
        step(0, 1, 0, 0, 0);
        check("t1_busy_after_start", int'(busy), 1);
        idle(67);
        check("t1_value_67", int'(value), 16);
        idle(1);
        check("t1_value_68", int'(value), 17);
        check("t1_full_68", int'(full), 1);
        check("t1_busy_68", int'(busy), 0);
        idle(5);
        check("t1_hold", int'(value), 17);

        // Manual ops in ARMED.
        step(1, 0, 0, 0, 100);
        step(0, 0, 1, 0, 0); check("t2_inc1", int'(value), 1);
        step(0, 0, 1, 0, 0); check("t2_inc2", int'(value), 2);
        step(0, 0, 1, 0, 0); check("t2_inc3", int'(value), 3);
        step(0, 0, 0, 1, 0); check("t2_mul1", int'(value), 6);
        step(0, 0, 0, 1, 0); check("t2_mul2", int'(value), 12);
        idle(10);
        check("t2_no_tick", int'(value), 12);
        check("t2_busy", int'(busy), 0);

        // Doubling past the terminal with carry out.
        step(1, 0, 0, 0, 200);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0);
        check("t3_192", int'(value), 192);
        check("t3_no_ovf_yet", int'(overflow), 0);
        step(0, 0, 0, 1, 0);
        check("t3_sat", int'(value), 200);
        check("t3_full", int'(full), 1);
        check("t3_ovf", int'(overflow), 1);

        // inc coinciding with a tick clamps to terminal.
        step(1, 0, 0, 0, 10);
        step(0, 1, 0, 0, 0);
        idle(36);
        check("t4_value9", int'(value), 9);
        idle(3);
        step(0, 0, 1, 0, 0);
        check("t4_clamp", int'(value), 10);
        check("t4_full", int'(full), 1);

        // Zero terminal goes straight to DONE.
        step(1, 0, 0, 0, 0);
        check("t5_value", int'(value), 0);
        check("t5_full", int'(full), 1);
        step(0, 1, 1, 0, 0);
        check("t5_busy", int'(busy), 0);
        check("t5_still_full", int'(full), 1);

        // latch beats start.
        step(1, 1, 0, 0, 30);
        check("latch_over_start", int'(busy), 0);

        // Reset mid-RUN.
        step(1, 0, 0, 0, 50);
        step(0, 1, 0, 0, 0);
        idle(20);
        check("t6_value5", int'(value), 5);
        do_reset();
        check("t6_rst_value", int'(value), 0);
        check("t6_rst_busy", int'(busy), 0);
        step(0, 1, 0, 0, 0);
        check("t6_idle_start", int'(busy), 0);
        step(0, 0, 1, 0, 0);
        check("t6_idle_inc", int'(value), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            int d;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0)
                d = 0;
            else if ($urandom_range(0, 1) == 1)
                d = int'($urandom_range(1, 40));
            else
                d = int'($urandom_range(1, 255));
            step($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 14) == 0, d);
            rst = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/count_uptimer.md
Name: count_uptimer

Overview:
- Up-counting timer; the opposite-direction companion to the team's 8-bit down-timer.
- Latches an 8-bit terminal value and clears its count to 0.
- Counts up by auto ticks from a prescaler, by manual `inc` pulses, or by doubling with `mul2`, until it reaches the terminal value.
- Used to measure elapsed intervals and to generate timeouts alongside the down-timer in the same timer subsystem.

Parameters:
- WIDTH, 8, width of the count and terminal registers.
- PRESCALE, 4, clock cycles per auto tick while in RUN; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  terminal value, sampled when latch=1.
- latch  input  1  loads terminal<=in, sets value<=0, enters ARMED.
- start  input  1  ARMED->RUN; ignored in all other states.
- inc  input  1  manual +1 to value; honoured in ARMED and RUN.
- mul2  input  1  value<=value<<1; honoured in ARMED and RUN.
- value  output  WIDTH  current count, registered.
- full  output  1  registered; 1 when value==terminal.
- busy  output  1  registered; 1 in state RUN.
- overflow  output  1  sticky; set on a mul2 that shifts out a 1.

Behaviour:
- Reset (rst=1 at an edge):
  - value=0, terminal=0, full=0, busy=0, overflow=0.
  - prescaler count=0, state=IDLE.
  - rst overrides every other input, including mid-RUN.
- States:
  - IDLE: after reset. Only latch has effect.
  - ARMED: terminal loaded. Manual ops allowed; no auto ticks.
  - RUN: manual ops allowed; prescaler runs.
  - DONE: value frozen at terminal, full=1. Only latch or rst leave DONE.
- Input priority each edge, highest first: rst, latch, mul2, inc, auto tick.
- latch, in any state:
  - terminal<=in, value<=0, overflow<=0, prescaler<=0, full<=0.
  - Next state is ARMED.
  - If in==0, next state is DONE instead, with full=1; zero latency beyond the one edge.
  - If latch and start are both high, latch wins and start is ignored.
- start in ARMED: next state RUN, prescaler<=0, busy=1 from the following cycle.
- Prescaler in RUN:
  - Increments every cycle.
  - When it reaches PRESCALE-1 it wraps to 0 and generates a tick.
  - The first tick after start occurs PRESCALE cycles after the start edge.
- Update rule, computed in WIDTH+1 bits:
  - If mul2: next = value<<1. Bit WIDTH set -> overflow<=1.
  - Else the sum of inc (0/1) and tick (0/1) is added, so inc and tick in the same cycle add 2.
  - A tick coinciding with mul2 is dropped; the prescaler still wraps.
- Saturation: if next>=terminal (including on overflow), value<=terminal, full<=1, state DONE, busy<=0. Otherwise value<=next[WIDTH-1:0].
- inc/mul2/start are ignored in IDLE and DONE.
- mul2 with value==0 leaves value at 0; this is not an error.
- No wrap-around of value ever occurs; it saturates at terminal.

Optional Feature:
- Macro UPTIMER_IRQ_EN.
- When defined: adds output `done_pulse` (1 bit, reset 0). It is high for exactly one cycle on the cycle after entry to DONE. It does not re-fire while the block remains in DONE, and it does fire for a latch with in=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then latch in=17, start, no manual ops, PRESCALE=4 -> value increments every 4 cycles; value=17, full=1, busy=0 at 68 cycles after start; value holds at 17 thereafter.
- latch in=100, in ARMED: inc x3, then mul2 x2 -> value 1,2,3,6,12; busy=0; no auto ticks.
- latch in=200, inc to 3, mul2 x7 -> 6,12,24,48,96,192, then 384≥200 -> value=200, full=1, overflow=1, DONE.
- latch in=10, start, wait until value=9, then inc on the same cycle as a tick -> next=11, clamped to 10, full=1.
- latch in=0 -> next cycle value=0, full=1, state DONE; start/inc ignored; with UPTIMER_IRQ_EN, done_pulse high for one cycle.
- In RUN with value=5, assert rst -> next cycle value=0, full=0, busy=0, overflow=0; start without a latch -> stays IDLE.
